// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: R-type func codes,
// FSM state encoding and the default divide iteration count.
package mdu_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'd16;
  localparam logic [5:0] FUNC_MTHI  = 6'd17;
  localparam logic [5:0] FUNC_MFLO  = 6'd18;
  localparam logic [5:0] FUNC_MTLO  = 6'd19;
  localparam logic [5:0] FUNC_MULT  = 6'd24;
  localparam logic [5:0] FUNC_MULTU = 6'd25;
  localparam logic [5:0] FUNC_DIV   = 6'd26;
  localparam logic [5:0] FUNC_DIVU  = 6'd27;

  localparam int unsigned DIV_ITERS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Restoring divider datapath: load latches magnitudes, each step retires one
// quotient bit. The next-step values are exposed so the final step can commit.
module div_iter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_next,
  output logic [W-1:0] rem_next
);

  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // diff[W] set means the trial subtract went negative: keep the shifted value
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[W]) begin
      rem_next = diff[W-1:0];
      quo_next = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller owning HI/LO; stalls the pipe until a
// result commits. Define MDU_FAST_DIV0_EN to resolve divide-by-zero in 1 cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [5:0]  func,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] hilo_rdata,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  mdu_state_e  state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [CW-1:0] cnt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sgn;
  logic        q_neg;
  logic        r_neg;

  logic        is_mul;
  logic        is_div;
  logic        div_sgn;
  logic        div0_fast;
  logic        div_load;
  logic        div_step;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] quo_next;
  logic [31:0] rem_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    is_mul  = (func == FUNC_MULT) || (func == FUNC_MULTU);
    is_div  = (func == FUNC_DIV) || (func == FUNC_DIVU);
    div_sgn = (func == FUNC_DIV);
    a_abs   = (div_sgn && rs_data[31]) ? -rs_data : rs_data;
    b_abs   = (div_sgn && rt_data[31]) ? -rt_data : rt_data;
  end

`ifdef MDU_FAST_DIV0_EN
  assign div0_fast = (rt_data == '0);
`else
  assign div0_fast = 1'b0;
`endif

  assign div_load = (state == ST_IDLE) && valid_i && is_div && !flush && !div0_fast;
  assign div_step = (state == ST_DIV) && !flush;

  div_iter #(.W(DIV_ITERS)) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // 64-bit product of extended operands is correct for both signednesses
  always_comb begin
    a_ext = mul_sgn ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
    b_ext = mul_sgn ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
    prod  = a_ext * b_ext;
    q_fix = q_neg ? -quo_next : quo_next;
    r_fix = r_neg ? -rem_next : rem_next;
  end

  assign stall_o = !flush && (((state == ST_IDLE) && valid_i && (is_mul || is_div))
                              || (state == ST_MUL) || (state == ST_DIV));
  assign busy_o  = (state != ST_IDLE);

  always_comb begin
    hilo_rdata = '0;
    if (func == FUNC_MFHI) hilo_rdata = hi;
    else if (func == FUNC_MFLO) hilo_rdata = lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (func == FUNC_MTHI) hi <= rs_data;
            if (func == FUNC_MTLO) lo <= rs_data;
            if (is_mul) begin
              mul_a   <= rs_data;
              mul_b   <= rt_data;
              mul_sgn <= (func == FUNC_MULT);
              state   <= ST_MUL;
            end
            if (is_div) begin
              if (div0_fast) begin
                hi    <= rs_data;
                lo    <= (div_sgn && rs_data[31]) ? 32'd1 : '1;
                state <= ST_DONE;
              end else begin
                q_neg <= div_sgn && (rs_data[31] ^ rt_data[31]);
                r_neg <= div_sgn && rs_data[31];
                cnt   <= '0;
                state <= ST_DIV;
              end
            end
          end
        end
        ST_MUL: begin
          hi    <= prod[63:32];
          lo    <= prod[31:0];
          state <= ST_DONE;
        end
        ST_DIV: begin
          if (cnt == LAST_ITER) begin
            hi    <= r_fix;
            lo    <= q_fix;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: multiply, divide, divide-by-zero,
// overflow, flush and reset behaviour with hand-computed HI/LO values.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [5:0]  func;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        stall_o;
  logic [31:0] hilo_rdata;
  logic        busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef MDU_FAST_DIV0_EN
  localparam int DIV0_STALLS = 1;
`else
  localparam int DIV0_STALLS = 33;
`endif

  mdu_ctrl #(.DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .func       (func),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .flush      (flush),
    .stall_o    (stall_o),
    .hilo_rdata (hilo_rdata),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one instruction and hold it until the stall drops; stall count bounded.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    @(negedge clk);
    valid_i = 1'b1; func = f; rs_data = a; rt_data = b;
    #1;
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    valid_i = 1'b0; func = 6'd0;
  endtask

  task automatic read_reg(input logic [5:0] f, output logic [31:0] v);
    func = f;
    #1;
    v = hilo_rdata;
    func = 6'd0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1; valid_i = 1'b0; func = 6'd0; rs_data = '0; rt_data = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall_o); else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy_o); else pass_cnt++;
    read_reg(6'd16, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_hi got %h exp 00000000", v); else pass_cnt++;
    read_reg(6'd18, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_lo got %h exp 00000000", v); else pass_cnt++;
  endtask

  task automatic test_ignored;
    int s;
    run_op(6'd32, 32'd1, 32'd2, s);
    total_cnt++;
    if (s !== 0) $display("FAIL ignored_stall got %0d exp 0", s); else pass_cnt++;
  endtask

  task automatic test_mul;
    int s;
    logic [31:0] h, l;
    run_op(6'd24, 32'hFFFFFFFE, 32'd3, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (s !== 2) $display("FAIL mult_stall got %0d exp 2", s); else pass_cnt++;
    total_cnt++;
    if (h !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h exp FFFFFFFF", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'hFFFFFFFA) $display("FAIL mult_lo got %h exp FFFFFFFA", l); else pass_cnt++;
    run_op(6'd25, 32'hFFFFFFFE, 32'd3, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (s !== 2) $display("FAIL multu_stall got %0d exp 2", s); else pass_cnt++;
    total_cnt++;
    if (h !== 32'h00000002) $display("FAIL multu_hi got %h exp 00000002", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'hFFFFFFFA) $display("FAIL multu_lo got %h exp FFFFFFFA", l); else pass_cnt++;
  endtask

  task automatic test_div;
    int s;
    logic [31:0] h, l;
    run_op(6'd26, 32'hFFFFFFF9, 32'd2, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (s !== 33) $display("FAIL div_stall got %0d exp 33", s); else pass_cnt++;
    total_cnt++;
    if (l !== 32'hFFFFFFFD) $display("FAIL div_lo got %h exp FFFFFFFD", l); else pass_cnt++;
    total_cnt++;
    if (h !== 32'hFFFFFFFF) $display("FAIL div_hi got %h exp FFFFFFFF", h); else pass_cnt++;
    run_op(6'd27, 32'd100, 32'd7, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (l !== 32'd14) $display("FAIL divu_lo got %h exp 0000000e", l); else pass_cnt++;
    total_cnt++;
    if (h !== 32'd2) $display("FAIL divu_hi got %h exp 00000002", h); else pass_cnt++;
  endtask

  task automatic test_div0;
    int s;
    logic [31:0] h, l;
    run_op(6'd27, 32'h12345678, 32'd0, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (s !== DIV0_STALLS) $display("FAIL divu0_stall got %0d exp %0d", s, DIV0_STALLS); else pass_cnt++;
    total_cnt++;
    if (h !== 32'h12345678) $display("FAIL divu0_hi got %h exp 12345678", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'hFFFFFFFF) $display("FAIL divu0_lo got %h exp FFFFFFFF", l); else pass_cnt++;
    run_op(6'd26, 32'hFFFFFFF0, 32'd0, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (h !== 32'hFFFFFFF0) $display("FAIL div0neg_hi got %h exp FFFFFFF0", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'h00000001) $display("FAIL div0neg_lo got %h exp 00000001", l); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int s;
    logic [31:0] h, l;
    run_op(6'd26, 32'h80000000, 32'hFFFFFFFF, s);
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (s !== 33) $display("FAIL ovf_stall got %0d exp 33", s); else pass_cnt++;
    total_cnt++;
    if (l !== 32'h80000000) $display("FAIL ovf_lo got %h exp 80000000", l); else pass_cnt++;
    total_cnt++;
    if (h !== 32'h0) $display("FAIL ovf_hi got %h exp 00000000", h); else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL ovf_busy got %0b exp 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_flush;
    int s;
    logic [31:0] h, l;
    run_op(6'd17, 32'hAAAA0000, 32'd0, s);
    run_op(6'd19, 32'h0000BBBB, 32'd0, s);
    @(negedge clk);
    valid_i = 1'b1; func = 6'd26; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall got %0b exp 0", stall_o); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0; valid_i = 1'b0; func = 6'd0;
    #1;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL flush_busy got %0b exp 0", busy_o); else pass_cnt++;
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (h !== 32'hAAAA0000) $display("FAIL flush_hi got %h exp AAAA0000", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'h0000BBBB) $display("FAIL flush_lo got %h exp 0000BBBB", l); else pass_cnt++;
    run_op(6'd24, 32'd3, 32'd5, s);
    read_reg(6'd18, l);
    total_cnt++;
    if (s !== 2) $display("FAIL flush_mult_stall got %0d exp 2", s); else pass_cnt++;
    total_cnt++;
    if (l !== 32'd15) $display("FAIL flush_mult_lo got %h exp 0000000f", l); else pass_cnt++;
  endtask

  task automatic test_mthi_mfhi;
    int s;
    logic [31:0] h;
    run_op(6'd17, 32'hDEADBEEF, 32'd0, s);
    read_reg(6'd16, h);
    total_cnt++;
    if (h !== 32'hDEADBEEF) $display("FAIL mthi_mfhi got %h exp DEADBEEF", h); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul;
    logic [31:0] h, l;
    @(negedge clk);
    valid_i = 1'b1; func = 6'd24; rs_data = 32'h7; rt_data = 32'h9;
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; func = 6'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL rstmul_stall got %0b exp 0", stall_o); else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL rstmul_busy got %0b exp 0", busy_o); else pass_cnt++;
    read_reg(6'd16, h); read_reg(6'd18, l);
    total_cnt++;
    if (h !== 32'h0) $display("FAIL rstmul_hi got %h exp 00000000", h); else pass_cnt++;
    total_cnt++;
    if (l !== 32'h0) $display("FAIL rstmul_lo got %h exp 00000000", l); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_ignored;
    test_mul;
    test_div;
    test_div0;
    test_overflow;
    test_flush;
    test_mthi_mfhi;
    test_reset_mid_mul;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
